// File: rtl/sync_tx_pkg.sv
// Shared definitions for the sync-word transmitter: state encoding, default
// sync pattern, idle line level and counter sizing.
package sync_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_DATA = 2'd2,
      ST_STOP = 2'd3
   } state_e;

   localparam logic [3:0]  SYNC_PAT_DEFAULT = 4'b0110;
   localparam logic        IDLE_LEVEL       = 1'b1;
   localparam int unsigned SYNC_LEN         = 32'd4;

   // One counter serves both the sync word and the payload, so size it for the longer.
   function automatic int unsigned cnt_width(input int unsigned data_w);
      int unsigned longest;
      longest = (data_w > SYNC_LEN) ? data_w : SYNC_LEN;
      return $clog2(longest);
   endfunction

endpackage

// File: rtl/sync_tx_shreg.sv
// Payload shift register: parallel load, MSB-first shift with zero fill,
// exposes only the current MSB.
module sync_tx_shreg #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic         shift_i,
   input  logic [W-1:0] d_i,
   output logic         msb_o
);

   logic [W-1:0] sh_q;
   logic [W-1:0] sh_d;

   // Load has priority over shift; otherwise hold.
   always_comb begin
      sh_d = sh_q;
      if (load_i) begin
         sh_d = d_i;
      end else if (shift_i) begin
         sh_d = {sh_q[W-2:0], 1'b0};
      end else begin
         sh_d = sh_q;
      end
   end

   // Shift register state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_q <= '0;
      end else begin
         sh_q <= sh_d;
      end
   end

   assign msb_o = sh_q[W-1];

endmodule

// File: rtl/sync_tx.sv
// Serial frame transmitter: sync word, MSB-first payload and a stop bit, with
// registered Moore outputs and one idle cycle between back-to-back frames.
module sync_tx
   import sync_tx_pkg::*;
#(
   parameter int unsigned DATA_W   = 8,
   parameter logic [3:0]  SYNC_PAT = SYNC_PAT_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              send,
   input  logic [DATA_W-1:0] data_in,
   output logic              ready,
   output logic              x_out,
   output logic              frame,
   output logic              done
);

   localparam int unsigned CNT_W = cnt_width(DATA_W);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             x_q;
   logic             ready_q;
   logic             frame_q;
   logic             done_q;
   logic             load_s;
   logic             shift_s;
   logic             msb_s;

   sync_tx_shreg #(
      .W(DATA_W)
   ) u_shreg (
      .clk    (clk),
      .reset  (reset),
      .load_i (load_s),
      .shift_i(shift_s),
      .d_i    (data_in),
      .msb_o  (msb_s)
   );

   // The payload MSB is put on the line on the same edge that shifts it out.
   always_comb begin
      load_s  = 1'b0;
      shift_s = 1'b0;
      case (state_q)
         ST_IDLE: load_s  = send;
         ST_SYNC: shift_s = (cnt_q == '0);
         ST_DATA: shift_s = 1'b1;
         default: begin
            load_s  = 1'b0;
            shift_s = 1'b0;
         end
      endcase
   end

   // Frame sequencer with bit counter and registered line outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         x_q     <= IDLE_LEVEL;
         ready_q <= 1'b1;
         frame_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (send) begin
                  state_q <= ST_SYNC;
                  cnt_q   <= CNT_W'(SYNC_LEN - 32'd1);
                  x_q     <= SYNC_PAT[3];
                  ready_q <= 1'b0;
                  frame_q <= 1'b1;
                  done_q  <= 1'b0;
               end else begin
                  cnt_q   <= '0;
                  x_q     <= IDLE_LEVEL;
                  ready_q <= 1'b1;
                  frame_q <= 1'b0;
                  done_q  <= 1'b0;
               end
            end
            ST_SYNC: begin
               if (cnt_q == '0) begin
                  state_q <= ST_DATA;
                  cnt_q   <= CNT_W'(DATA_W - 32'd1);
                  x_q     <= msb_s;
               end else begin
                  cnt_q   <= cnt_q - 1'b1;
                  x_q     <= SYNC_PAT[cnt_q[1:0] - 2'd1];
               end
            end
            ST_DATA: begin
               if (cnt_q == '0) begin
                  state_q <= ST_STOP;
                  x_q     <= IDLE_LEVEL;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q   <= cnt_q - 1'b1;
                  x_q     <= msb_s;
               end
            end
            ST_STOP: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               x_q     <= IDLE_LEVEL;
               ready_q <= 1'b1;
               frame_q <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               x_q     <= IDLE_LEVEL;
               ready_q <= 1'b1;
               frame_q <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ready = ready_q;
   assign x_out = x_q;
   assign frame = frame_q;
   assign done  = done_q;

endmodule

// File: tb/tb_sync_tx.sv
// Scoreboard bench for sync_tx: the stimulus side predicts each frame bit with
// its cycle number, a monitor checks the line every cycle.
module tb_sync_tx;

   localparam int         DW  = 8;
   localparam int         FL  = 4 + DW + 1;
   localparam logic [3:0] PAT = 4'b0110;
   localparam int         NEVER = 1 << 30;

   typedef struct {
      int   cyc;
      logic x;
      logic dn;
   } exp_t;

   logic          clk;
   logic          reset;
   logic          send;
   logic [DW-1:0] data_in;
   logic          ready, x_out, frame, done;
   logic          send4;
   logic [3:0]    data4;
   logic          ready4, x4, frame4, done4;
   logic [8:0]    bits4;

   int   n_cmp;
   int   n_err;
   int   cyc;
   int   next_ok;
   exp_t sb[$];
   exp_t mon_e;
   logic mon_exp;

   sync_tx #(.DATA_W(DW), .SYNC_PAT(PAT)) dut (
      .clk(clk), .reset(reset), .send(send), .data_in(data_in),
      .ready(ready), .x_out(x_out), .frame(frame), .done(done)
   );

   sync_tx #(.DATA_W(4)) dut4 (
      .clk(clk), .reset(reset), .send(send4), .data_in(data4),
      .ready(ready4), .x_out(x4), .frame(frame4), .done(done4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Drive inputs now and, if the reference says the transmitter is idle at the
   // coming edge, queue the 13 expected line bits with their cycle numbers.
   task automatic drive(input logic s, input logic [DW-1:0] d);
      logic [FL-1:0] fr;
      int e;
      send    = s;
      data_in = d;
      e = cyc + 1;
      if (s && !reset && e >= next_ok) begin
         fr = {PAT, d, 1'b1};
         for (int i = 0; i < FL; i++) begin
            sb.push_back('{cyc: e + i, x: fr[FL-1-i], dn: (i == FL - 1)});
         end
         next_ok = e + FL + 1;
      end
   endtask

   task automatic step(input logic s, input logic [DW-1:0] d);
      @(negedge clk);
      drive(s, d);
   endtask

   // Monitor: every cycle outside reset, compare the line against the scoreboard.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (!reset) begin
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            n_cmp++;
            n_err++;
            $display("FAIL stale_entry at cycle %0d: bit for cycle %0d never shown", cyc, sb[0].cyc);
            void'(sb.pop_front());
         end
         mon_exp = (sb.size() > 0 && sb[0].cyc == cyc);
         chk("frame", frame, mon_exp);
         if (mon_exp) begin
            mon_e = sb.pop_front();
            chk("x_out", x_out, mon_e.x);
            chk("done", done, mon_e.dn);
            chk("ready_busy", ready, 1'b0);
         end else begin
            chk("x_out_idle", x_out, 1'b1);
            chk("done_idle", done, 1'b0);
            chk("ready_idle", ready, 1'b1);
         end
      end
   end

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      cyc     = 0;
      next_ok = NEVER;
      reset   = 1'b1;
      send    = 1'b0;
      send4   = 1'b0;
      data_in = '0;
      data4   = 4'h0;
      bits4   = 9'h000;

      #3;
      chk("rst_x_out", x_out, 1'b1);
      chk("rst_ready", ready, 1'b1);
      chk("rst_frame", frame, 1'b0);
      chk("rst_done", done, 1'b0);

      // First edge after release accepts a frame.
      repeat (2) @(negedge clk);
      reset   = 1'b0;
      next_ok = cyc + 1;
      drive(1'b1, 8'hA5);
      step(1'b0, 8'h00);
      repeat (16) step(1'b0, 8'($urandom));

      // send held high: back-to-back frames with one idle cycle.
      step(1'b1, 8'h3C);
      repeat (20) step(1'b1, 8'hFF);
      repeat (10) step(1'b0, 8'h00);

      // A send pulse mid-frame is ignored and not queued.
      step(1'b1, 8'h81);
      repeat (5) step(1'b0, 8'h81);
      step(1'b1, 8'h00);
      repeat (14) step(1'b0, 8'h00);

      // Asynchronous reset in the middle of the payload.
      step(1'b1, 8'h5A);
      repeat (7) step(1'b0, 8'h5A);
      @(negedge clk);
      #2;
      reset   = 1'b1;
      sb.delete();
      next_ok = NEVER;
      #1;
      chk("async_rst_x_out", x_out, 1'b1);
      chk("async_rst_ready", ready, 1'b1);
      chk("async_rst_frame", frame, 1'b0);
      chk("async_rst_done", done, 1'b0);
      @(negedge clk);
      reset   = 1'b0;
      next_ok = cyc + 1;
      drive(1'b1, 8'hC3);
      repeat (16) step(1'b0, 8'h00);

      // Random traffic with data changing during frames.
      repeat (400) step(($urandom_range(0, 3) == 0), 8'($urandom));
      repeat (20) step(1'b0, 8'h00);

      // Narrow payload instance: 9-cycle frame for 4'h9.
      @(negedge clk);
      send4 = 1'b1;
      data4 = 4'h9;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk);
         #1;
         send4 = 1'b0;
         bits4 = {bits4[7:0], x4};
         chk("frame4", frame4, 1'b1);
         chk("done4", done4, (i == 8));
      end
      chk("frame4_bits", bits4, 9'b011010011);
      @(posedge clk);
      #1;
      chk("x4_idle", x4, 1'b1);
      chk("ready4_idle", ready4, 1'b1);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sync_tx.md
SYNC_TX -- requirements
Module: sync_tx

Interface
REQ-001 Parameter DATA_W, default 8, payload bits per frame.
REQ-002 Parameter SYNC_PAT, default 4'b0110, 4-bit sync word sent MSB first ahead of every payload.
REQ-003 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1, asynchronous, active-high reset.
REQ-005 Port send, input, 1, request to transmit data_in; sampled only while ready=1.
REQ-006 Port data_in, input, DATA_W, payload captured on the accepting edge.
REQ-007 Port ready, output, 1, high only in IDLE; block can accept send.
REQ-008 Port x_out, output, 1, registered serial line; idle level 1.
REQ-009 Port frame, output, 1, high while a sync, data or stop bit is on x_out.
REQ-010 Port done, output, 1, one-cycle pulse coincident with the stop bit.

Function
REQ-011 States SHALL be IDLE, SYNC, DATA, STOP; no other reachable state, and an illegal encoding SHALL return to IDLE on the next edge.
REQ-012 IDLE: x_out=1, ready=1, frame=0, done=0; send=1 at an edge captures data_in into the shift register, loads the bit counter with 3, and enters SYNC.
REQ-013 Latency: the first sync bit, SYNC_PAT[3], SHALL appear on x_out immediately after the accepting edge (one-edge latency).
REQ-014 SYNC SHALL drive SYNC_PAT[3], [2], [1], [0] on four consecutive cycles, then enter DATA with the counter loaded to DATA_W-1.
REQ-015 DATA SHALL drive the captured payload MSB first, one bit per cycle, for exactly DATA_W cycles, then enter STOP.
REQ-016 STOP SHALL drive x_out=1 and done=1 for exactly one cycle, then enter IDLE.
REQ-017 A frame SHALL occupy exactly 4+DATA_W+1 cycles (13 at default) with frame=1 and ready=0.
REQ-018 send asserted while ready=0 SHALL be ignored and SHALL NOT be queued; data_in changes during a frame SHALL NOT affect the frame.
REQ-019 Back-to-back: with send held at 1, the next frame SHALL be accepted on the edge that finds the block in IDLE, giving exactly one idle cycle (x_out=1) between the stop bit and the next sync bit.
REQ-020 The counter SHALL be $clog2(max(4,DATA_W)) bits wide and SHALL never wrap; a terminal count of 0 triggers the state change.
REQ-021 All outputs SHALL be registered Moore outputs, glitch-free, and derived from state only.

Reset
REQ-022 reset=1 SHALL immediately, with no clock, force state=IDLE, x_out=1, ready=1, frame=0, done=0, counter=0, and shift register=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no stop bit and no done pulse; the first edge after reset deassertion SHALL behave as IDLE.
REQ-024 send sampled high on the first edge after reset release SHALL start a frame normally.

Structure
REQ-025 State encodings, SYNC_PAT default and idle line level SHALL live in a shared parameter include, reused by the matching sequence-recognizer blocks.
REQ-026 The payload shifter SHALL be one sub-module, sync_tx_shreg (parallel load, MSB-first shift, enable), and the FSM plus counter SHALL stay in sync_tx.

Verification
REQ-027 Reset then send=1 with data_in=8'hA5 for one cycle -> x_out sequence 0,1,1,0,1,0,1,0,0,1,0,1,1, then 1 idle; done high only on the 13th bit.
REQ-028 send held at 1 with data_in=8'h3C then 8'hFF -> two 13-bit frames separated by exactly one idle cycle; ready low for 13 cycles each.
REQ-029 send pulsed at frame cycle 6 with data_in=8'h00 during an 8'h81 frame -> the frame is unchanged and no second frame starts.
REQ-030 reset asserted asynchronously mid-DATA (between edges) -> x_out=1, ready=1 within the same cycle; no done pulse; a fresh send after release gives a full frame.
REQ-031 Loopback into the team's 0110 Moore recognizer with payload 8'hF0 -> exactly one detect per frame, aligned to the end of the sync word.
REQ-032 DATA_W=4, data_in=4'h9 -> a 9-cycle frame 0,1,1,0,1,0,0,1,1.
